grf_writeback_arbiter: RTL and testbench
========================================

// Module: grf_writeback_arbiter
// PURPOSE
//   Write-side front end of the GRF in the pipelined CPU. Merges main-pipeline writebacks with
//   late results from multi-cycle units (MDU, loads) into the single GRF write port.
//   Main path has priority. Aux results wait in a small FIFO and drain in idle write slots.
//   Exports a pending-write mask so the hazard unit can stall on registers not yet written.
// PARAMETERS
//   DEPTH  2  aux FIFO entries (power of two, >=2)
//   PTR_W  1  log2(DEPTH)
//   CNT_W  2  log2(DEPTH)+1, width of aux_count
// PORTS
//   clk          in   1      clock; all state updates on the rising edge
//   reset        in   1      synchronous, active-high reset
//   wb_valid     in   1      main-pipeline writeback valid this cycle (no backpressure)
//   wb_addr      in   5      main writeback destination register
//   wb_data      in   32     main writeback data
//   wb_pc        in   32     PC of the main writeback instruction
//   aux_valid    in   1      aux result offered
//   aux_ready    out  1      aux FIFO can accept; transfer when aux_valid && aux_ready
//   aux_addr     in   5      aux destination register
//   aux_data     in   32     aux result data
//   aux_pc       in   32     PC of the aux-producing instruction
//   grf_we       out  1      GRF write enable (registered)
//   grf_waddr    out  5      GRF write address (registered)
//   grf_wdata    out  32     GRF write data (registered)
//   grf_pc       out  32     PC of the write, for the GRF write log (registered)
//   pending_mask out  32     bit r = 1 when a live FIFO entry targets $r; bit 0 always 0
//   aux_count    out  CNT_W  number of occupied FIFO entries, including killed entries
// BEHAVIOUR
//   - Reset: FIFO flushed, pointers 0, and all entries invalidated. grf_we/waddr/wdata/pc = 0.
//     pending_mask = 0, aux_count = 0, aux_ready = 1. Reset overrides all same-cycle events.
//   - Output stage is registered. A write selected in cycle N is driven in cycle N+1,
//     and the GRF commits it at the end of N+1.
//   - Main slot: taken in cycle N when wb_valid && wb_addr != 0. That cycle registers
//     {1, wb_addr, wb_data, wb_pc}.
//   - A main write with wb_valid && wb_addr == 0 is dropped and leaves the slot free.
//   - Aux drain: if the main slot is free and the FIFO head is live, the head is popped and
//     {1, addr, data, pc} is registered.
//   - Killed head: a killed head is popped in any cycle, even while the main slot is taken.
//     It produces no write.
//   - Otherwise grf_we <= 0; the addr, data and pc outputs hold their values.
//   - Enqueue: aux_ready = (aux_count != DEPTH), from registered state only, with no pop
//     look-ahead. On a handshake the entry is written at the tail with a live bit.
//   - An aux handshake with aux_addr == 0 is accepted and discarded; nothing is stored.
//   - Earliest aux write: aux is accepted in cycle N, may pop in N+1, and is driven in N+2.
//     There is no bypass.
//   - Squash (WAW): when the main slot is taken for register R, every live FIFO entry with
//     addr R is marked killed. An entry accepted in the same cycle with aux_addr == R is
//     stored killed. The newer main write always wins.
//   - Push and pop in the same cycle: both happen; aux_count is unchanged.
//   - Pointers wrap modulo DEPTH.
//   - pending_mask: combinational OR of one-hot(addr) over live entries. It excludes the
//     output register; the hazard unit forwards from grf_we/grf_waddr itself.
//   - FIFO order is preserved. Aux writes to the same register commit oldest first.
// TESTING
//   1. Reset: assert reset 2 cycles -> grf_we=0, aux_ready=1, aux_count=0, pending_mask=0.
//   2. Main path: wb_valid=1, wb_addr=5, wb_data=0x1234, wb_pc=0x3000 in cycle N -> in N+1:
//      grf_we=1, waddr=5, wdata=0x1234, pc=0x3000.
//   3. Main to $0: wb_addr=0 -> grf_we=0 next cycle. Aux to $0 is accepted and aux_count
//      stays 0.
//   4. Aux under load: push {8, 0xAA, 0x3010} while wb_valid=1, wb_addr=3 every cycle.
//      -> aux_count=1, pending_mask=0x100, no aux write.
//      Then drop wb_valid in cycle M -> in M+1: grf_we=1, waddr=8, wdata=0xAA;
//      mask=0, count=0.
//   5. Full/backpressure (DEPTH=2): push addr 6 and addr 7 under main load -> aux_ready=0.
//      A held third offer is not taken. One idle cycle -> aux_ready=1 and 6 is written
//      before 7.
//   6. Squash and reset mid-op:
//      - Pending aux to $9, then main write to $9 (0x55) -> only 0x55 is written;
//        bit 9 clears; the killed entry pops with no write.
//      - With 2 live entries, assert reset -> count=0 and no later grf_we.

Source files
------------

// File: rtl/grf_wb_if.sv
// Bundle of the GRF write-side signals: main writeback, aux result offer, and GRF write outputs.
// master = producer side (pipeline/testbench), slave = the arbiter.
interface grf_wb_if #(
    parameter int CNT_W = 2
);
    logic             wb_valid;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;
    logic [31:0]      wb_pc;

    // aux_valid/aux_ready: a transfer happens on a rising edge where both are 1.
    // aux_ready depends only on registered state; aux_valid may be held across cycles.
    logic             aux_valid;
    logic             aux_ready;
    logic [4:0]       aux_addr;
    logic [31:0]      aux_data;
    logic [31:0]      aux_pc;

    logic             grf_we;
    logic [4:0]       grf_waddr;
    logic [31:0]      grf_wdata;
    logic [31:0]      grf_pc;
    logic [31:0]      pending_mask;
    logic [CNT_W-1:0] aux_count;

    modport master (
        output wb_valid, wb_addr, wb_data, wb_pc,
        output aux_valid, aux_addr, aux_data, aux_pc,
        input  aux_ready,
        input  grf_we, grf_waddr, grf_wdata, grf_pc, pending_mask, aux_count
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, wb_pc,
        input  aux_valid, aux_addr, aux_data, aux_pc,
        output aux_ready,
        output grf_we, grf_waddr, grf_wdata, grf_pc, pending_mask, aux_count
    );
endinterface

// File: rtl/grf_writeback_arbiter.sv
// Merges main-pipeline writebacks and queued multi-cycle results onto the single GRF write port.
// Main path has priority; aux results drain from a small FIFO in free slots, newer main writes kill stale aux entries.
module grf_writeback_arbiter #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1,
    parameter int CNT_W = 2
) (
    input  logic      clk,
    input  logic      reset,
    grf_wb_if.slave   bus
);

    // FIFO storage; live_q marks entries that will still produce a write
    logic             live_q [DEPTH];
    logic             live_d [DEPTH];
    logic [4:0]       addr_q [DEPTH];
    logic [4:0]       addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             grf_we_q, grf_we_d;
    logic [4:0]       grf_waddr_q, grf_waddr_d;
    logic [31:0]      grf_wdata_q, grf_wdata_d;
    logic [31:0]      grf_pc_q, grf_pc_d;

    logic             main_take;
    logic             fifo_full;
    logic             head_occ;
    logic             head_live;
    logic             push;
    logic             pop;
    logic             drain;
    logic [31:0]      mask;

    always_comb begin
        main_take = bus.wb_valid && (bus.wb_addr != 5'd0);
        fifo_full = (count_q == CNT_W'(DEPTH));
        head_occ  = (count_q != '0);
        head_live = live_q[rd_ptr_q];
        // Address-0 offers complete the handshake but are never stored
        push      = bus.aux_valid && !fifo_full && (bus.aux_addr != 5'd0);
        // Killed heads leave regardless of the main slot; live heads need a free slot
        drain     = head_occ && head_live && !main_take;
        pop       = head_occ && (!head_live || !main_take);
    end

    // FIFO next state: squash, then pop, then push (push never lands on the popped head)
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            live_d[i] = live_q[i];
            addr_d[i] = addr_q[i];
            data_d[i] = data_q[i];
            pc_d[i]   = pc_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (main_take) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == bus.wb_addr) begin
                    live_d[i] = 1'b0;
                end
            end
        end

        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            live_d[wr_ptr_q] = !(main_take && (bus.aux_addr == bus.wb_addr));
            addr_d[wr_ptr_q] = bus.aux_addr;
            data_d[wr_ptr_q] = bus.aux_data;
            pc_d[wr_ptr_q]   = bus.aux_pc;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Output stage: address, data and pc hold when no write is selected
    always_comb begin
        grf_we_d    = 1'b0;
        grf_waddr_d = grf_waddr_q;
        grf_wdata_d = grf_wdata_q;
        grf_pc_d    = grf_pc_q;
        if (main_take) begin
            grf_we_d    = 1'b1;
            grf_waddr_d = bus.wb_addr;
            grf_wdata_d = bus.wb_data;
            grf_pc_d    = bus.wb_pc;
        end else if (drain) begin
            grf_we_d    = 1'b1;
            grf_waddr_d = addr_q[rd_ptr_q];
            grf_wdata_d = data_q[rd_ptr_q];
            grf_pc_d    = pc_q[rd_ptr_q];
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                mask[addr_q[i]] = 1'b1;
            end
        end
        mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= 1'b0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            grf_we_q    <= 1'b0;
            grf_waddr_q <= '0;
            grf_wdata_q <= '0;
            grf_pc_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= live_d[i];
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
                pc_q[i]   <= pc_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            grf_we_q    <= grf_we_d;
            grf_waddr_q <= grf_waddr_d;
            grf_wdata_q <= grf_wdata_d;
            grf_pc_q    <= grf_pc_d;
        end
    end

    assign bus.aux_ready    = !fifo_full;
    assign bus.aux_count    = count_q;
    assign bus.pending_mask = mask;
    assign bus.grf_we       = grf_we_q;
    assign bus.grf_waddr    = grf_waddr_q;
    assign bus.grf_wdata    = grf_wdata_q;
    assign bus.grf_pc       = grf_pc_q;

endmodule

// File: tb/tb_grf_writeback_arbiter.sv
// Directed bench for grf_writeback_arbiter: a vector table for the main path plus
// hand-written sequences for aux queueing, backpressure, squash and mid-operation reset.
module tb_grf_writeback_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    grf_wb_if #(.CNT_W(2)) bus ();

    grf_writeback_arbiter #(.DEPTH(2), .PTR_W(1), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_valid;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] wb_pc;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic main_drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        bus.wb_valid = v;
        bus.wb_addr  = a;
        bus.wb_data  = d;
        bus.wb_pc    = pc;
    endtask

    task automatic aux_drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        bus.aux_valid = v;
        bus.aux_addr  = a;
        bus.aux_data  = d;
        bus.aux_pc    = pc;
    endtask

    task automatic chk_write(input string name, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        chk({name, "_we"}, 32'(bus.grf_we), 32'd1);
        chk({name, "_waddr"}, 32'(bus.grf_waddr), 32'(a));
        chk({name, "_wdata"}, bus.grf_wdata, d);
        chk({name, "_pc"}, bus.grf_pc, pc);
    endtask

    task automatic chk_fifo(input string name, input logic [31:0] cnt, input logic [31:0] msk);
        chk({name, "_count"}, 32'(bus.aux_count), cnt);
        chk({name, "_mask"}, bus.pending_mask, msk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        main_drive(1'b0, 5'd0, 32'h0, 32'h0);
        aux_drive(1'b0, 5'd0, 32'h0, 32'h0);

        vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 32'h0000_3000, 1'b1, 5'd5,  32'h0000_1234, 32'h0000_3000};
        vecs[1] = '{1'b1, 5'd0,  32'hdead_beef, 32'h0000_3004, 1'b0, 5'd5,  32'h0000_1234, 32'h0000_3000};
        vecs[2] = '{1'b0, 5'd7,  32'h0bad_0bad, 32'h0000_3008, 1'b0, 5'd5,  32'h0000_1234, 32'h0000_3000};
        vecs[3] = '{1'b1, 5'd31, 32'hffff_ffff, 32'h0000_300c, 1'b1, 5'd31, 32'hffff_ffff, 32'h0000_300c};
        vecs[4] = '{1'b1, 5'd1,  32'h0000_0000, 32'h0000_3010, 1'b1, 5'd1,  32'h0000_0000, 32'h0000_3010};
        vecs[5] = '{1'b0, 5'd1,  32'h1111_1111, 32'h0000_3014, 1'b0, 5'd1,  32'h0000_0000, 32'h0000_3010};

        // Reset held two cycles
        step();
        step();
        chk("rst_we", 32'(bus.grf_we), 32'd0);
        chk("rst_ready", 32'(bus.aux_ready), 32'd1);
        chk("rst_waddr", 32'(bus.grf_waddr), 32'd0);
        chk("rst_wdata", bus.grf_wdata, 32'd0);
        chk_fifo("rst", 32'd0, 32'd0);
        reset = 1'b0;

        // Main path vectors
        for (int i = 0; i < 6; i++) begin
            main_drive(vecs[i].wb_valid, vecs[i].wb_addr, vecs[i].wb_data, vecs[i].wb_pc);
            step();
            chk($sformatf("vec%0d_we", i), 32'(bus.grf_we), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_waddr", i), 32'(bus.grf_waddr), 32'(vecs[i].exp_waddr));
            chk($sformatf("vec%0d_wdata", i), bus.grf_wdata, vecs[i].exp_wdata);
            chk($sformatf("vec%0d_pc", i), bus.grf_pc, vecs[i].exp_pc);
            chk_fifo($sformatf("vec%0d", i), 32'd0, 32'd0);
        end
        main_drive(1'b0, 5'd0, 32'h0, 32'h0);

        // Aux to $0 is accepted and discarded
        aux_drive(1'b1, 5'd0, 32'h77, 32'h3020);
        #1;
        chk("aux0_ready", 32'(bus.aux_ready), 32'd1);
        step();
        aux_drive(1'b0, 5'd0, 32'h0, 32'h0);
        chk_fifo("aux0", 32'd0, 32'd0);
        step();
        chk("aux0_we", 32'(bus.grf_we), 32'd0);

        // Aux under main load, drains when the main slot frees
        main_drive(1'b1, 5'd3, 32'h33, 32'h3100);
        aux_drive(1'b1, 5'd8, 32'hAA, 32'h3010);
        step();
        aux_drive(1'b0, 5'd0, 32'h0, 32'h0);
        chk_write("load1", 5'd3, 32'h33, 32'h3100);
        chk_fifo("load1", 32'd1, 32'h100);
        step();
        chk_write("load2", 5'd3, 32'h33, 32'h3100);
        chk_fifo("load2", 32'd1, 32'h100);
        main_drive(1'b0, 5'd0, 32'h0, 32'h0);
        step();
        chk_write("drain8", 5'd8, 32'hAA, 32'h3010);
        chk_fifo("drain8", 32'd0, 32'd0);

        // Fill to DEPTH under load, hold a third offer, then drain in order
        main_drive(1'b1, 5'd3, 32'h33, 32'h3100);
        aux_drive(1'b1, 5'd6, 32'h66, 32'h3200);
        step();
        aux_drive(1'b1, 5'd7, 32'h67, 32'h3204);
        step();
        chk("full_ready", 32'(bus.aux_ready), 32'd0);
        chk_fifo("full", 32'd2, 32'h0000_00c0);
        aux_drive(1'b1, 5'd9, 32'h99, 32'h3208);
        step();
        step();
        chk_fifo("held", 32'd2, 32'h0000_00c0);
        main_drive(1'b0, 5'd0, 32'h0, 32'h0);
        aux_drive(1'b0, 5'd0, 32'h0, 32'h0);
        step();
        chk_write("full_w6", 5'd6, 32'h66, 32'h3200);
        chk("full_ready_after", 32'(bus.aux_ready), 32'd1);
        chk_fifo("full_w6", 32'd1, 32'h0000_0080);
        step();
        chk_write("full_w7", 5'd7, 32'h67, 32'h3204);
        chk_fifo("full_w7", 32'd0, 32'd0);

        // Squash: pending $9 killed by a newer main write to $9
        main_drive(1'b1, 5'd3, 32'h33, 32'h3100);
        aux_drive(1'b1, 5'd9, 32'h99, 32'h3300);
        step();
        aux_drive(1'b0, 5'd0, 32'h0, 32'h0);
        chk_fifo("sq_pend", 32'd1, 32'h200);
        main_drive(1'b1, 5'd9, 32'h55, 32'h3304);
        step();
        chk_write("sq_main", 5'd9, 32'h55, 32'h3304);
        chk_fifo("sq_main", 32'd1, 32'd0);
        main_drive(1'b0, 5'd0, 32'h0, 32'h0);
        step();
        chk("sq_pop_we", 32'(bus.grf_we), 32'd0);
        chk("sq_pop_wdata", bus.grf_wdata, 32'h55);
        chk_fifo("sq_pop", 32'd0, 32'd0);

        // Same-cycle push to the register the main write targets is stored killed
        main_drive(1'b1, 5'd12, 32'hC0, 32'h3400);
        aux_drive(1'b1, 5'd12, 32'hC1, 32'h3404);
        step();
        main_drive(1'b0, 5'd0, 32'h0, 32'h0);
        aux_drive(1'b0, 5'd0, 32'h0, 32'h0);
        chk_write("sq_same", 5'd12, 32'hC0, 32'h3400);
        chk_fifo("sq_same", 32'd1, 32'd0);
        step();
        chk("sq_same_we", 32'(bus.grf_we), 32'd0);
        chk_fifo("sq_same_pop", 32'd0, 32'd0);

        // Push and pop in one cycle keep the count; same-register entries commit oldest first
        main_drive(1'b1, 5'd3, 32'h33, 32'h3100);
        aux_drive(1'b1, 5'd13, 32'hD1, 32'h3500);
        step();
        main_drive(1'b0, 5'd0, 32'h0, 32'h0);
        aux_drive(1'b1, 5'd13, 32'hD2, 32'h3504);
        step();
        aux_drive(1'b0, 5'd0, 32'h0, 32'h0);
        chk_write("pp_first", 5'd13, 32'hD1, 32'h3500);
        chk_fifo("pp_first", 32'd1, 32'h2000);
        step();
        chk_write("pp_second", 5'd13, 32'hD2, 32'h3504);
        chk_fifo("pp_second", 32'd0, 32'd0);

        // Reset with two live entries flushes them
        main_drive(1'b1, 5'd3, 32'h33, 32'h3100);
        aux_drive(1'b1, 5'd10, 32'hA0, 32'h3600);
        step();
        aux_drive(1'b1, 5'd11, 32'hB0, 32'h3604);
        step();
        aux_drive(1'b0, 5'd0, 32'h0, 32'h0);
        chk_fifo("pre_rst", 32'd2, 32'h0000_0c00);
        main_drive(1'b0, 5'd0, 32'h0, 32'h0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_fifo("mid_rst", 32'd0, 32'd0);
        chk("mid_rst_ready", 32'(bus.aux_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_rst%0d_we", i), 32'(bus.grf_we), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
